gbuf_banked: RTL and testbench

Parametrised multi-bank global buffer: BANKS single-port synchronous RAMs of DATA_BITS × 2^ADDR_BITS each, addressed in scalar mode (one element, bank chosen by low index bits) or vector mode (one element per bank, same row). It adds a registered read-valid, a registered bank-select on the read path, and a burst engine that streams words in from a valid/ready source or out to a valid/ready sink with full backpressure. It sits between the host/DMA side and the systolic array's operand feeders, replacing the fixed four-bank buffer.

---
 rtl/gbuf_pkg.sv | 17 +
 rtl/gbuf_banked_if.sv | 43 ++++
 rtl/gbuf_bank.sv | 26 ++
 rtl/gbuf_banked.sv | 233 +++++++++++++++++++++++
 tb/tb_gbuf_banked.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/gbuf_pkg.sv
// Shared encodings for the banked global buffer.
package gbuf_pkg;

  localparam logic MODE_SCALAR = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_DRAIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gbuf_banked_if.sv
// Host/DMA-facing bus of the banked global buffer: direct access, burst control, load/drain streams.
interface gbuf_banked_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BANKS     = 4
);
  localparam int unsigned BANK_BITS = $clog2(BANKS);
  localparam int unsigned IDX_BITS  = ADDR_BITS + BANK_BITS;
  localparam int unsigned WORD_BITS = BANKS * DATA_BITS;

  logic                 mode;
  logic                 wr_en;
  logic                 rd_en;
  logic [IDX_BITS-1:0]  index;
  logic [WORD_BITS-1:0] data_in;
  logic [WORD_BITS-1:0] data_out;
  logic                 rd_valid;
  logic                 burst_start;
  logic                 burst_dir;
  logic [IDX_BITS-1:0]  burst_base;
  logic [IDX_BITS:0]    burst_len;
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_BITS-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [WORD_BITS-1:0] m_data;
  logic                 burst_busy;
  logic                 burst_done;

  modport master (
    output mode, wr_en, rd_en, index, data_in, burst_start, burst_dir, burst_base, burst_len,
           s_valid, s_data, m_ready,
    input  data_out, rd_valid, s_ready, m_valid, m_data, burst_busy, burst_done
  );

  modport slave (
    input  mode, wr_en, rd_en, index, data_in, burst_start, burst_dir, burst_base, burst_len,
           s_valid, s_data, m_ready,
    output data_out, rd_valid, s_ready, m_valid, m_data, burst_busy, burst_done
  );

endinterface

// File: rtl/gbuf_bank.sv
// One single-port synchronous RAM bank; a read returns the contents before any same-cycle write.
module gbuf_bank #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  // Array write and registered read of the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gbuf_banked.sv
// Multi-bank global buffer with scalar/vector direct access and a backpressured burst engine.
module gbuf_banked #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BANKS     = 4
) (
  input logic          clk,
  input logic          rst,
  gbuf_banked_if.slave bus
);
  import gbuf_pkg::*;

  localparam int unsigned BANK_BITS = $clog2(BANKS);
  localparam int unsigned IDX_BITS  = ADDR_BITS + BANK_BITS;
  localparam int unsigned WORD_BITS = BANKS * DATA_BITS;
  localparam int unsigned LEN_BITS  = IDX_BITS + 1;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [IDX_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]  left_q, left_d;   // words still to write (load) or issue (drain)
  logic [LEN_BITS-1:0]  acc_q, acc_d;     // drain words still to be accepted by the sink
  logic                 inflight_q, inflight_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [BANK_BITS-1:0] sel_q, sel_d;
  logic                 rmode_q, rmode_d;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic [WORD_BITS-1:0] fifo_q [2];
  logic [WORD_BITS-1:0] fifo_d [2];
  logic                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d, s_ready_q, s_ready_d, done_q, done_d;

  logic                 do_wr, do_rd, burst_rd, pop, use_mode;
  logic [IDX_BITS-1:0]  use_idx;
  logic [WORD_BITS-1:0] use_wdata, rd_word_c, data_out_c, m_data_c;
  logic                 m_valid_c;
  logic [ADDR_BITS-1:0] ram_row;
  logic [BANKS-1:0]     ram_we, ram_re;
  logic [DATA_BITS-1:0] bank_wdata [BANKS];
  logic [DATA_BITS-1:0] bank_rdata [BANKS];

  function automatic logic [IDX_BITS-1:0] idx_inc(input logic [IDX_BITS-1:0] idx, input logic m);
    if (m == MODE_VECTOR) return IDX_BITS'(ADDR_BITS'(idx[ADDR_BITS-1:0] + ADDR_BITS'(1)));
    return idx + IDX_BITS'(1);
  endfunction

  function automatic logic [ADDR_BITS-1:0] row_of(input logic [IDX_BITS-1:0] idx, input logic m);
    return (m == MODE_VECTOR) ? idx[ADDR_BITS-1:0] : idx[IDX_BITS-1:BANK_BITS];
  endfunction

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    gbuf_bank #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_bank (
      .clk   (clk),
      .we    (ram_we[b]),
      .re    (ram_re[b]),
      .addr  (ram_row),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Assemble the word returned by the last read using its registered bank select and mode.
  always_comb begin
    rd_word_c = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (rmode_q == MODE_VECTOR) rd_word_c[b*DATA_BITS +: DATA_BITS] = bank_rdata[b];
    end
    if (rmode_q == MODE_SCALAR) rd_word_c[DATA_BITS-1:0] = bank_rdata[sel_q];
  end

  assign data_out_c = rd_valid_q ? rd_word_c : hold_q;
  assign m_valid_c  = (cnt_q != 2'd0);
  assign m_data_c   = m_valid_c ? fifo_q[rptr_q] : '0;

  // Next-state, RAM port arbitration, burst counters and drain FIFO.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    left_d     = left_q;
    acc_d      = acc_q;
    sel_d      = sel_q;
    rmode_d    = rmode_q;
    hold_d     = data_out_c;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    burst_rd   = 1'b0;
    use_mode   = bus.mode;
    use_idx    = bus.index;
    use_wdata  = bus.data_in;
    pop        = m_valid_c && bus.m_ready;

    if (state_q == IDLE || state_q == DONE) begin
      do_wr = bus.wr_en;
      do_rd = bus.rd_en && !bus.wr_en;
    end

    case (state_q)
      IDLE: begin
        if (bus.burst_start) begin
          mode_d = bus.mode;
          addr_d = bus.burst_base;
          left_d = bus.burst_len;
          acc_d  = bus.burst_len;
          if (bus.burst_len == '0) begin
            state_d = DONE;
          end else if (bus.burst_dir == DIR_DRAIN) begin
            // First drain read is issued in the start cycle so m_valid rises two cycles later.
            state_d  = DRAIN;
            do_wr    = 1'b0;
            do_rd    = 1'b1;
            burst_rd = 1'b1;
            use_idx  = bus.burst_base;
            addr_d   = idx_inc(bus.burst_base, bus.mode);
            left_d   = bus.burst_len - LEN_BITS'(1);
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          do_wr     = 1'b1;
          use_mode  = mode_q;
          use_idx   = addr_q;
          use_wdata = bus.s_data;
          addr_d    = idx_inc(addr_q, mode_q);
          left_d    = left_q - LEN_BITS'(1);
          if (left_q == LEN_BITS'(1)) state_d = DONE;
        end
      end
      DRAIN: begin
        if (pop) begin
          acc_d = acc_q - LEN_BITS'(1);
          if (acc_q == LEN_BITS'(1)) state_d = DONE;
        end
        // Issue only if the word can land in the FIFO, counting the read in flight and this pop.
        if (left_q != '0 && (3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop))) begin
          do_rd    = 1'b1;
          burst_rd = 1'b1;
          use_mode = mode_q;
          use_idx  = addr_q;
          addr_d   = idx_inc(addr_q, mode_q);
          left_d   = left_q - LEN_BITS'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_rd) begin
      sel_d   = use_idx[BANK_BITS-1:0];
      rmode_d = use_mode;
    end
    rd_valid_d = do_rd && !burst_rd;
    inflight_d = burst_rd;

    if (inflight_q) begin
      fifo_d[wptr_q] = rd_word_c;
      wptr_d         = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + 2'(inflight_q) - 2'(pop);

    busy_d    = (state_d == LOAD) || (state_d == DRAIN);
    s_ready_d = (state_d == LOAD);
    done_d    = (state_q == DONE);

    ram_row = row_of(use_idx, use_mode);
    for (int b = 0; b < BANKS; b++) begin
      ram_we[b] = do_wr && (use_mode == MODE_VECTOR || use_idx[BANK_BITS-1:0] == BANK_BITS'(b));
      ram_re[b] = do_rd && (use_mode == MODE_VECTOR || use_idx[BANK_BITS-1:0] == BANK_BITS'(b));
      bank_wdata[b] = (use_mode == MODE_VECTOR) ? use_wdata[b*DATA_BITS +: DATA_BITS]
                                                : use_wdata[DATA_BITS-1:0];
    end
  end

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_SCALAR;
      addr_q     <= '0;
      left_q     <= '0;
      acc_q      <= '0;
      inflight_q <= 1'b0;
      rd_valid_q <= 1'b0;
      sel_q      <= '0;
      rmode_q    <= MODE_SCALAR;
      hold_q     <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      busy_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      acc_q      <= acc_d;
      inflight_q <= inflight_d;
      rd_valid_q <= rd_valid_d;
      sel_q      <= sel_d;
      rmode_q    <= rmode_d;
      hold_q     <= hold_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      s_ready_q  <= s_ready_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out   = data_out_c;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.s_ready    = s_ready_q;
  assign bus.m_valid    = m_valid_c;
  assign bus.m_data     = m_data_c;
  assign bus.burst_busy = busy_q;
  assign bus.burst_done = done_q;

endmodule

// File: tb/tb_gbuf_banked.sv
// Directed self-checking bench for gbuf_banked (ADDR_BITS=8, DATA_BITS=8, BANKS=4).
module tb_gbuf_banked;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   k, dn;
  logic beat;

  gbuf_banked_if bus ();

  gbuf_banked dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Load/drain test word k: lane b = 0x40 + 0x20*b + k.
  function automatic logic [31:0] word(input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'(8'h40 + 8'(32 * b) + 8'(k));
    return w;
  endfunction

  task automatic dwrite(input logic m, input logic [9:0] idx, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.mode = m; bus.index = idx; bus.data_in = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic dread(input string tag, input logic m, input logic [9:0] idx,
                       input logic [31:0] exp);
    bus.rd_en = 1'b1; bus.mode = m; bus.index = idx;
    @(negedge clk);
    bus.rd_en = 1'b0; bus.index = ~idx;
    check({tag, "_vld"}, 64'(bus.rd_valid), 64'd1);
    check({tag, "_dat"}, 64'(bus.data_out), 64'(exp));
  endtask

  task automatic start_burst(input logic dir, input logic m, input logic [9:0] base,
                             input logic [10:0] len);
    bus.burst_start = 1'b1; bus.burst_dir = dir; bus.mode = m;
    bus.burst_base = base; bus.burst_len = len;
    @(negedge clk);
    bus.burst_start = 1'b0;
  endtask

  // Drain len words from base and compare them in order against word(k0+i).
  task automatic run_drain(input string tag, input logic m, input logic [9:0] base,
                           input int len, input int k0, input bit rnd);
    int got, ndone, extra;
    got = 0; ndone = 0; extra = 0;
    start_burst(1'b1, m, base, 11'(len));
    for (int c = 0; c < 300 && extra < 4; c++) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.burst_start = (c == 3);
      bus.burst_len = '0;
      if (bus.m_valid && bus.m_ready) begin
        check({tag, "_word"}, 64'(bus.m_data), 64'(word(k0 + got)));
        got++;
      end
      @(negedge clk);
      if (bus.burst_done) ndone++;
      if (got >= len) extra++;
    end
    bus.m_ready = 1'b0;
    bus.burst_start = 1'b0;
    check({tag, "_count"}, 64'(got), 64'(len));
    check({tag, "_done"}, 64'(ndone), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.mode = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.index = '0; bus.data_in = '0;
    bus.burst_start = 1'b0; bus.burst_dir = 1'b0; bus.burst_base = '0; bus.burst_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_s_ready",  64'(bus.s_ready), 64'd0);
    check("rst_m_valid",  64'(bus.m_valid), 64'd0);
    check("rst_m_data",   64'(bus.m_data), 64'd0);
    check("rst_busy",     64'(bus.burst_busy), 64'd0);
    check("rst_done",     64'(bus.burst_done), 64'd0);

    // Scalar writes and reads
    for (int i = 0; i < 8; i++) dwrite(1'b0, 10'(i), 32'(8'h10 + 8'(i)));
    dread("sc_rd5", 1'b0, 10'd5, 32'h0000_0015);
    @(negedge clk);
    check("sc_hold_vld", 64'(bus.rd_valid), 64'd0);
    check("sc_hold_dat", 64'(bus.data_out), 64'h15);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.mode = 1'b0; bus.index = 10'd6; bus.data_in = 32'h66;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("wr_wins_vld", 64'(bus.rd_valid), 64'd0);
    dread("wr_wins_rd", 1'b0, 10'd6, 32'h66);

    // Vector write, scalar and vector reads
    dwrite(1'b1, 10'd3, 32'hDDCC_BBAA);
    dread("vec_sc13", 1'b0, 10'd13, 32'h0000_00BB);
    dread("vec_row3", 1'b1, 10'd3, 32'hDDCC_BBAA);
    dread("vec_row0", 1'b1, 10'd0, 32'h1312_1110);

    // Vector load burst wrapping past row 255 with s_valid every other cycle
    start_burst(1'b0, 1'b1, 10'd250, 11'd10);
    check("ld_busy", 64'(bus.burst_busy), 64'd1);
    check("ld_s_ready", 64'(bus.s_ready), 64'd1);
    k = 0; dn = 0;
    for (int c = 0; c < 40; c++) begin
      bus.s_valid = (c % 2 == 1) && (k < 10);
      bus.s_data = word(k);
      beat = bus.s_valid && bus.s_ready;
      @(negedge clk);
      if (beat) k++;
      if (bus.burst_done) dn++;
    end
    bus.s_valid = 1'b0;
    check("ld_beats", 64'(k), 64'd10);
    check("ld_done", 64'(dn), 64'd1);
    check("ld_idle_busy", 64'(bus.burst_busy), 64'd0);
    for (int i = 0; i < 10; i++) dread("ld_row", 1'b1, 10'((250 + i) % 256), word(i));

    // Scalar drain with m_ready high: exact latency and throughput
    bus.m_ready = 1'b1;
    start_burst(1'b1, 1'b0, 10'd4, 11'd4);
    check("drA_mv0", 64'(bus.m_valid), 64'd0);
    check("drA_busy", 64'(bus.burst_busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drA_mv", 64'(bus.m_valid), 64'd1);
      check("drA_word", 64'(bus.m_data), 64'(8'h47 + 8'(32 * i)));
    end
    @(negedge clk);
    check("drA_end_mv", 64'(bus.m_valid), 64'd0);
    check("drA_end_busy", 64'(bus.burst_busy), 64'd0);
    check("drA_done_early", 64'(bus.burst_done), 64'd0);
    @(negedge clk);
    check("drA_done", 64'(bus.burst_done), 64'd1);
    bus.m_ready = 1'b0;
    @(negedge clk);

    // Vector drain under random backpressure, with an ignored start mid-burst
    run_drain("drB", 1'b1, 10'd252, 8, 2, 1'b1);

    // Zero-length burst
    start_burst(1'b0, 1'b1, 10'd7, 11'd0);
    check("z_done_t1", 64'(bus.burst_done), 64'd0);
    check("z_busy", 64'(bus.burst_busy), 64'd0);
    check("z_s_ready", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("z_done_t2", 64'(bus.burst_done), 64'd1);
    check("z_m_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    check("z_done_t3", 64'(bus.burst_done), 64'd0);

    // Reset in the middle of a stalled drain
    start_burst(1'b1, 1'b1, 10'd250, 11'd10);
    repeat (3) @(negedge clk);
    check("rs_pre_mv", 64'(bus.m_valid), 64'd1);
    check("rs_pre_md", 64'(bus.m_data), 64'(word(0)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_m_valid", 64'(bus.m_valid), 64'd0);
    check("rs_m_data",  64'(bus.m_data), 64'd0);
    check("rs_busy",    64'(bus.burst_busy), 64'd0);
    check("rs_s_ready", 64'(bus.s_ready), 64'd0);
    check("rs_data_out", 64'(bus.data_out), 64'd0);
    @(negedge clk);
    check("rs_no_done", 64'(bus.burst_done), 64'd0);
    run_drain("rsB", 1'b1, 10'd250, 3, 0, 1'b0);
    dread("rs_row3", 1'b1, 10'd3, word(9));
    dread("rs_row255", 1'b1, 10'd255, word(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
